// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its pending-bit scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_RD   = 2;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned RA_REG   = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit array: one bit per register, set by issue, cleared by writeback.
// A same-cycle set wins over clear, and entry 0 is held at zero.
module regfile_scoreboard #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 set_i,
  input  logic [ADDR_W-1:0]    set_addr_i,
  input  logic                 clr_i,
  input  logic [ADDR_W-1:0]    clr_addr_i,
  output logic [2**ADDR_W-1:0] pending_o,
  output logic                 any_o
);
  import regfile_pkg::*;

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] pending_d, pending_q;

  // Set is applied after clear: a new producer issued in the writeback cycle keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_addr_i] = 1'b0;
    if (set_i) pending_d[set_addr_i] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign any_o     = |pending_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with r0 hardwired to zero and a pending-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_mp #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_RD = regfile_pkg::NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     sb_any
);
  import regfile_pkg::*;

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  pending;
  logic              wr_valid;

  assign wr_valid = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .set_i      (sb_set),
    .set_addr_i (sb_addr),
    .clr_i      (wr_en),
    .clr_addr_i (wr_addr),
    .pending_o  (pending),
    .any_o      (sb_any)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so the read ports stay at zero throughout reset.
    always_comb begin
      data = regs_q[addr];
      if (rst_n && wr_valid && (wr_addr == addr)) data = wr_data;
    end
`else
    assign data = regs_q[addr];
`endif

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = pending[addr];
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized and directed bench for register_file_mp (NUM_RD=4) with a queue-based scoreboard.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    busy;
    logic             any;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic             sb_any;

  register_file_mp #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .sb_any  (sb_any)
  );

  always #5 clk = ~clk;

  // Reference state: register contents and pending flags, indexed by register number.
  logic [DW-1:0] mem  [32];
  bit            pend [32];

  exp_t  exp_q [$];
  string tag_q [$];
  int    errors = 0;
  int    checks = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (rd_data !== e.data) begin
        errors++;
        $display("FAIL %s rd_data: got %h expected %h", t, rd_data, e.data);
      end
      checks++;
      if (rd_busy !== e.busy) begin
        errors++;
        $display("FAIL %s rd_busy: got %b expected %b", t, rd_busy, e.busy);
      end
      checks++;
      if (sb_any !== e.any) begin
        errors++;
        $display("FAIL %s sb_any: got %b expected %b", t, sb_any, e.any);
      end
    end
  end

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input bit en, input int a, input logic [DW-1:0] d);
    wr_en   = en;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic set_sb(input bit s, input int a);
    sb_set  = s;
    sb_addr = AW'(a);
  endtask

  // Predict outputs for the inputs now applied, queue them, then advance one clock.
  task automatic step(input string tag);
    exp_t          e;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = '0;
        pend[i] = 1'b0;
      end
    end
    e = '0;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && wr_addr == a && a != 0) v = wr_data;
`endif
      e.data[p*DW +: DW] = v;
      e.busy[p]          = pend[a];
    end
    for (int i = 0; i < 32; i++) e.any = e.any | pend[i];
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst_n) begin
      if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
      if (wr_en) pend[wr_addr] = 1'b0;
      if (sb_set && sb_addr != 0) pend[sb_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_rd(0, 0, 0, 0);
    set_wr(1'b0, 0, '0);
    set_sb(1'b0, 0);
    @(posedge clk);
    #1;
    set_rd(1, 5, 9, 31);
    step("reset_a");
    step("reset_b");
    rst_n = 1'b1;

    // First write lands on the first edge after release, then both ports see it.
    set_wr(1'b1, 5, 32'hDEADBEEF);
    set_rd(5, 5, 0, 0);
    step("wr_r5");
    set_wr(1'b0, 0, '0);
    step("rd_r5");

    // Register 0 ignores writes and scoreboard sets.
    set_wr(1'b1, 0, 32'h1234);
    set_rd(0, 0, 0, 0);
    step("wr_r0");
    set_wr(1'b0, 0, '0);
    set_sb(1'b1, 0);
    step("rd_r0");
    set_sb(1'b0, 0);
    step("sb_r0");

    // Same-cycle read of a register being written.
    set_wr(1'b1, 7, 32'hA5A5);
    set_rd(7, 7, 7, 7);
    step("wr_rd_r7");
    set_wr(1'b0, 0, '0);
    step("rd_r7");

    // Pending set, clear by write, then set+write together keeps pending.
    set_rd(9, 0, 9, 5);
    set_sb(1'b1, 9);
    step("sb_set_r9");
    set_sb(1'b0, 0);
    step("busy_r9");
    set_wr(1'b1, 9, 32'h99);
    step("wr_r9");
    set_wr(1'b0, 0, '0);
    step("clr_r9");
    set_wr(1'b1, 9, 32'h199);
    set_sb(1'b1, 9);
    step("set_wr_r9");
    set_wr(1'b0, 0, '0);
    set_sb(1'b0, 0);
    step("keep_r9");

    // Fill r1..r31 with their own index, then a four-port read.
    for (int r = 1; r < 32; r++) begin
      set_wr(1'b1, r, DW'(r));
      step("fill");
    end
    set_wr(1'b0, 0, '0);
    set_rd(3, 3, 31, 0);
    step("rd_3_3_31_0");

    // Random traffic over a narrow address window so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
             $urandom_range(0, 7));
      set_wr(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      set_sb($urandom_range(0, 3) == 0, $urandom_range(0, 7));
      step("random");
    end

    // Leave something pending, then reset in the middle of a write.
    set_wr(1'b0, 0, '0);
    set_sb(1'b1, 20);
    step("sb_r20");
    set_sb(1'b0, 0);
    set_wr(1'b1, 12, 32'hCAFEF00D);
    set_rd(12, 20, 5, 31);
    rst_n = 1'b0;
    step("rst_mid_write");
    rst_n = 1'b1;
    set_wr(1'b1, 4, 32'h55);
    set_rd(12, 20, 4, 31);
    step("post_rst_wr");
    set_wr(1'b0, 0, '0);
    for (int r = 0; r < 32; r += 4) begin
      set_rd(r, r + 1, r + 2, r + 3);
      step("post_rst_scan");
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
